// File: rtl/led_frame_sequencer_pkg.sv
// rtl/led_frame_sequencer_pkg.sv - mode/state encodings and default widths for the LED frame sequencer
package led_frame_sequencer_pkg;

    localparam int C_W_LED_DEF   = 18;
    localparam int C_W_DIV_DEF   = 4;
    localparam int C_DIV_RST_DEF = 15;

    localparam logic [1:0] C_MODE_JOHNSON = 2'd0;
    localparam logic [1:0] C_MODE_ROTATE  = 2'd1;
    localparam logic [1:0] C_MODE_BLINK   = 2'd2;
    localparam logic [1:0] C_MODE_STATIC  = 2'd3;

    typedef enum logic [1:0] {
        MODE_JOHNSON = C_MODE_JOHNSON,
        MODE_ROTATE  = C_MODE_ROTATE,
        MODE_BLINK   = C_MODE_BLINK,
        MODE_STATIC  = C_MODE_STATIC
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - frame-synchronous LED pattern scheduler with frame-aligned command apply
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int C_W_LED   = C_W_LED_DEF,
    parameter int C_W_DIV   = C_W_DIV_DEF,
    parameter int C_DIV_RST = C_DIV_RST_DEF
) (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic               HVcy_i,
    input  logic               CMD_VLD_i,
    output logic               CMD_RDY_o,
    input  logic [1:0]         CMD_MODE_i,
    input  logic [C_W_DIV-1:0] CMD_DIV_i,
    input  logic [C_W_LED-1:0] CMD_PAT_i,
    output logic [C_W_LED-1:0] LEDs_ON_o,
    output logic [C_W_DIV-1:0] FCTRs_o,
    output logic               STEP_o,
    output logic [1:0]         MODE_o
);

    state_e             state_q, state_d;
    mode_e              sh_mode_q, sh_mode_d;
    logic [C_W_DIV-1:0] sh_div_q, sh_div_d;
    logic [C_W_LED-1:0] sh_pat_q, sh_pat_d;
    mode_e              mode_q, mode_d;
    logic [C_W_DIV-1:0] div_q, div_d;
    logic [C_W_LED-1:0] mask_q, mask_d;
    logic [C_W_LED-1:0] leds_q, leds_d;
    logic [C_W_DIV-1:0] fctr_q, fctr_d;
    logic               step_q, step_d;
    logic               rdy_q, rdy_d;
    logic [C_W_LED-1:0] leds_step;

    always_comb begin
        leds_step = leds_q;
        case (mode_q)
            MODE_JOHNSON: leds_step = {leds_q[C_W_LED-2:0], ~leds_q[C_W_LED-1]};
            MODE_ROTATE:  leds_step = {leds_q[C_W_LED-2:0], leds_q[C_W_LED-1]};
            MODE_BLINK:   leds_step = leds_q ^ mask_q;
            MODE_STATIC:  leds_step = leds_q;
            default:      leds_step = leds_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sh_mode_d = sh_mode_q;
        sh_div_d  = sh_div_q;
        sh_pat_d  = sh_pat_q;
        mode_d    = mode_q;
        div_d     = div_q;
        mask_d    = mask_q;
        leds_d    = leds_q;
        fctr_d    = fctr_q;
        step_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A frame pulse coinciding with acceptance still ticks with the old settings
                if (HVcy_i) begin
                    if (fctr_q == div_q) begin
                        fctr_d = '0;
                        leds_d = leds_step;
                        step_d = 1'b1;
                    end else begin
                        fctr_d = fctr_q + C_W_DIV'(1);
                    end
                end
                if (CMD_VLD_i && rdy_q) begin
                    sh_mode_d = mode_e'(CMD_MODE_i);
                    sh_div_d  = CMD_DIV_i;
                    sh_pat_d  = CMD_PAT_i;
                    state_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (HVcy_i) begin
                    mode_d  = sh_mode_q;
                    div_d   = sh_div_q;
                    mask_d  = sh_pat_q;
                    leds_d  = sh_pat_q;
                    fctr_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q   <= ST_IDLE;
            sh_mode_q <= MODE_JOHNSON;
            sh_div_q  <= '0;
            sh_pat_q  <= '0;
            mode_q    <= MODE_JOHNSON;
            div_q     <= C_W_DIV'(C_DIV_RST);
            mask_q    <= '0;
            leds_q    <= '0;
            fctr_q    <= '0;
            step_q    <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_mode_q <= sh_mode_d;
            sh_div_q  <= sh_div_d;
            sh_pat_q  <= sh_pat_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            mask_q    <= mask_d;
            leds_q    <= leds_d;
            fctr_q    <= fctr_d;
            step_q    <= step_d;
            rdy_q     <= rdy_d;
        end
    end

    assign CMD_RDY_o = rdy_q;
    assign LEDs_ON_o = leds_q;
    assign FCTRs_o   = fctr_q;
    assign STEP_o    = step_q;
    assign MODE_o    = mode_q;

endmodule
